// File: rtl/noc_vc_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_vc_queue : router input queue, NUM_VC virtual-channel FIFOs sharing   |
// |                one write and one registered read port, with credit return.|
// | Optional: define NOC_VC_QUEUE_ERR_EN to add sticky err_o[1:0].            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module noc_vc_queue #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 4,
  parameter  int NUM_VC = 2,
  localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req_i,
  input  logic [VCW-1:0]    push_vc_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              pop_req_i,
  input  logic [VCW-1:0]    pop_vc_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              valid_o,
  output logic [NUM_VC-1:0] full_o,
  output logic [NUM_VC-1:0] empty_o,
  output logic [NUM_VC-1:0] credit_o
`ifdef NOC_VC_QUEUE_ERR_EN
  ,
  output logic [1:0]        err_o
`endif
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]  mem_q    [NUM_VC][DEPTH];
  logic [WIDTH-1:0]  mem_d    [NUM_VC][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_VC];
  logic [PW-1:0]     wr_ptr_d [NUM_VC];
  logic [PW-1:0]     rd_ptr_q [NUM_VC];
  logic [PW-1:0]     rd_ptr_d [NUM_VC];
  logic [CW-1:0]     count_q  [NUM_VC];
  logic [CW-1:0]     count_d  [NUM_VC];

  logic [NUM_VC-1:0] push_sel;
  logic [NUM_VC-1:0] pop_sel;
  logic [NUM_VC-1:0] push_acc;
  logic [NUM_VC-1:0] pop_acc;

  logic [WIDTH-1:0]  data_q,   data_d;
  logic              valid_q,  valid_d;
  logic [NUM_VC-1:0] credit_q, credit_d;

  // Out-of-range VC indices never match any v, so such requests fall away.
  always_comb begin
    push_sel = '0;
    pop_sel  = '0;
    push_acc = '0;
    pop_acc  = '0;
    mem_d    = mem_q;
    data_d   = data_q;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      push_sel[v] = push_req_i && (push_vc_i == VCW'(v));
      pop_sel[v]  = pop_req_i  && (pop_vc_i  == VCW'(v));
      pop_acc[v]  = pop_sel[v] && (count_q[v] != '0);
      // A full VC still takes the push when the same-cycle pop frees a slot.
      push_acc[v] = push_sel[v] && ((count_q[v] != FULL_CNT) || pop_acc[v]);
      if (push_acc[v]) begin
        mem_d[v][wr_ptr_q[v]] = data_i;
        wr_ptr_d[v]           = wr_ptr_q[v] + PW'(1);
      end
      if (pop_acc[v]) begin
        data_d      = mem_q[v][rd_ptr_q[v]];
        rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
      end
      count_d[v] = count_q[v] + CW'(push_acc[v]) - CW'(pop_acc[v]);
    end
    valid_d  = |pop_acc;
    credit_d = pop_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      data_q   <= '0;
      valid_q  <= 1'b0;
      credit_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        count_q[v]  <= count_d[v];
      end
      data_q   <= data_d;
      valid_q  <= valid_d;
      credit_q <= credit_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_status
    assign full_o[v]  = (count_q[v] == FULL_CNT);
    assign empty_o[v] = (count_q[v] == '0);
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign credit_o = credit_q;

`ifdef NOC_VC_QUEUE_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (|(push_sel & ~push_acc));
    err_d[1] = err_q[1] | (|(pop_sel & ~pop_acc));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_noc_vc_queue : directed vector table plus randomized traffic checked   |
// |                   against a queue-based reference model.                  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_noc_vc_queue;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int NUM_VC = 2;

  logic        clk;
  logic        rst;
  logic        push_req_i;
  logic [0:0]  push_vc_i;
  logic [15:0] data_i;
  logic        pop_req_i;
  logic [0:0]  pop_vc_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic [1:0]  full_o;
  logic [1:0]  empty_o;
  logic [1:0]  credit_o;
`ifdef NOC_VC_QUEUE_ERR_EN
  logic [1:0]  err_o;
`endif

  noc_vc_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (push_req_i),
    .push_vc_i  (push_vc_i),
    .data_i     (data_i),
    .pop_req_i  (pop_req_i),
    .pop_vc_i   (pop_vc_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .credit_o   (credit_o)
`ifdef NOC_VC_QUEUE_ERR_EN
    ,
    .err_o      (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per VC plus the last popped flit.
  logic [15:0] m_q [2][$];
  logic [15:0] m_data;

  typedef struct {
    logic        push;
    int          pvc;
    logic [15:0] din;
    logic        pop;
    int          ovc;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ef;
    logic [1:0]  ee;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pu, int pv, logic [15:0] d, logic po, int ov,
                              logic ev, logic [15:0] ed, logic [1:0] ef,
                              logic [1:0] ee, logic [1:0] ec);
    vec_t r;
    r.push = pu; r.pvc = pv; r.din = d; r.pop = po; r.ovc = ov;
    r.ev = ev; r.ed = ed; r.ef = ef; r.ee = ee; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q[0].delete();
    m_q[1].delete();
    m_data = '0;
  endtask

  task automatic idle_inputs();
    push_req_i = 1'b0;
    push_vc_i  = '0;
    data_i     = '0;
    pop_req_i  = 1'b0;
    pop_vc_i   = '0;
  endtask

  // Drive one cycle of requests, then compare against the model's prediction.
  task automatic step(input logic pu, input int pv, input logic [15:0] d,
                      input logic po, input int ov);
    logic       pop_ok, push_ok, m_valid;
    logic [1:0] m_credit, m_full, m_empty;
    push_req_i = pu;
    push_vc_i  = pv[0];
    data_i     = d;
    pop_req_i  = po;
    pop_vc_i   = ov[0];
    @(posedge clk);
    #1;
    pop_ok   = po && (m_q[ov].size() > 0);
    push_ok  = pu && ((m_q[pv].size() < DEPTH) || (pop_ok && ov == pv));
    m_valid  = pop_ok;
    m_credit = '0;
    if (pop_ok) begin
      m_data       = m_q[ov].pop_front();
      m_credit[ov] = 1'b1;
    end
    if (push_ok) m_q[pv].push_back(d);
    for (int v = 0; v < 2; v++) begin
      m_full[v]  = (m_q[v].size() == DEPTH);
      m_empty[v] = (m_q[v].size() == 0);
    end
    chk("model_valid",  32'(valid_o),  32'(m_valid));
    chk("model_data",   32'(data_o),   32'(m_data));
    chk("model_full",   32'(full_o),   32'(m_full));
    chk("model_empty",  32'(empty_o),  32'(m_empty));
    chk("model_credit", 32'(credit_o), 32'(m_credit));
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //         push pv din       pop ov  ev   ed        full   empty  credit
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(1, 0, 16'hA001, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hA002, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hA003, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hA004, 0, 0, 0, 16'h0000, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hA005, 0, 0, 0, 16'h0000, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hA001, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hA002, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hA003, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hA004, 2'b00, 2'b11, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'hA004, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(1, 1, 16'h1111, 0, 0, 0, 16'hA004, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'hA004, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 16'h1111, 2'b00, 2'b10, 2'b10));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 2'b00, 2'b11, 2'b01));
    tbl.push_back(mk(1, 0, 16'hC001, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hC002, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hC003, 0, 0, 0, 16'h0000, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hC004, 0, 0, 0, 16'h0000, 2'b01, 2'b10, 2'b00));
    tbl.push_back(mk(1, 0, 16'hBEEF, 1, 0, 1, 16'hC001, 2'b01, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hC002, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hC003, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hC004, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'hBEEF, 2'b00, 2'b11, 2'b01));
    tbl.push_back(mk(1, 1, 16'h5A5A, 1, 1, 0, 16'hBEEF, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 16'h5A5A, 2'b00, 2'b11, 2'b10));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].push, tbl[i].pvc, tbl[i].din, tbl[i].pop, tbl[i].ovc);
      chk($sformatf("vec%0d_valid", i),  32'(valid_o),  32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i),   32'(data_o),   32'(tbl[i].ed));
      chk($sformatf("vec%0d_full", i),   32'(full_o),   32'(tbl[i].ef));
      chk($sformatf("vec%0d_empty", i),  32'(empty_o),  32'(tbl[i].ee));
      chk($sformatf("vec%0d_credit", i), 32'(credit_o), 32'(tbl[i].ec));
    end
`ifdef NOC_VC_QUEUE_ERR_EN
    // Both a dropped full push and empty pops occurred in the table.
    chk("err_sticky", 32'(err_o), 32'(2'b11));
`endif

    // Asynchronous reset in the middle of a fill.
    step(1, 0, 16'hD001, 0, 0);
    step(1, 0, 16'hD002, 0, 0);
    step(1, 0, 16'hD003, 0, 0);
    idle_inputs();
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_empty",  32'(empty_o),  32'(2'b11));
    chk("async_rst_full",   32'(full_o),   32'(2'b00));
    chk("async_rst_valid",  32'(valid_o),  32'(1'b0));
    chk("async_rst_data",   32'(data_o),   32'(16'h0000));
    chk("async_rst_credit", 32'(credit_o), 32'(2'b00));
`ifdef NOC_VC_QUEUE_ERR_EN
    chk("async_rst_err",    32'(err_o),    32'(2'b00));
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 16'h0000, 1, 0);
    chk("post_rst_pop_valid", 32'(valid_o), 32'(1'b0));

    // Random traffic, including same-VC and cross-VC simultaneous requests.
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 1)), 16'($urandom),
           ($urandom % 2) != 0, int'($urandom_range(0, 1)));
    end

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
